// File: rtl/datapath_seq.sv
// datapath_seq: parametrised single-bus CPU datapath with an on-chip T-state sequencer.
//   NREGS x W register file, Y, Z (2W), HI and LO, one shared bus with an encoded source
//   select, and an iterative shift-add multiplier. One ALU op runs per start/done handshake.
// Ports:
//   clk, clr                  clock and synchronous active-high reset (clr aborts a running op)
//   start, op, ra, rb, rc     op request, sampled only in IDLE; operands latched at capture
//   busy, done, err           sequencer status; done/err are one-cycle pulses
//   wr_en, wr_addr, wr_data   external register load, honoured only in IDLE
//   rd_addr, rd_data          combinational debug read of R[rd_addr]
//   hi_out, lo_out, z_out     HI, LO and Z registers
// Build option: define R0_ZERO_EN to hardwire R0 to zero (all writes to R0 dropped).
module datapath_seq #(
  parameter int unsigned W = 32,
  parameter int unsigned NREGS = 16,
  localparam int unsigned AW = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            start,
  input  logic [3:0]      op,
  input  logic [AW-1:0]   ra,
  input  logic [AW-1:0]   rb,
  input  logic [AW-1:0]   rc,
  output logic            busy,
  output logic            done,
  output logic            err,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [W-1:0]    wr_data,
  input  logic [AW-1:0]   rd_addr,
  output logic [W-1:0]    rd_data,
  output logic [W-1:0]    hi_out,
  output logic [W-1:0]    lo_out,
  output logic [2*W-1:0]  z_out
);

  localparam int unsigned SW = $clog2(W);
  localparam int unsigned CW = $clog2(W) + 1;

  localparam logic [3:0] OpMul  = 4'd8;
  localparam logic [3:0] OpMfhi = 4'd9;
  localparam logic [3:0] OpMflo = 4'd10;

  typedef enum logic [2:0] {StIdle, StT1, StT2, StTm, StT3, StDone} state_e;
  typedef enum logic [1:0] {BusReg, BusHi, BusLo, BusZlo} bus_sel_e;

  state_e            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [AW-1:0]     ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
  logic [W-1:0]      y_q, y_d, hi_q, hi_d, lo_q, lo_d, mq_q, mq_d;
  logic [2*W-1:0]    z_q, z_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [W-1:0]      regs_q [NREGS];
  logic [W-1:0]      regs_d [NREGS];
  logic              busy_q, done_q, err_q;

  bus_sel_e          bus_sel;
  logic [AW-1:0]     bus_idx;
  logic [W-1:0]      bus;
  logic [W-1:0]      alu;
  logic [W:0]        acc_sum;
  logic              illegal;
  logic              rf_we, rf_keep;
  logic [AW-1:0]     rf_waddr;
  logic [W-1:0]      rf_wdata;

  assign illegal = (op_q > OpMflo);

  // Bus source depends only on registered state, so the bus never loops through next-state logic.
  always_comb begin
    bus_sel = BusReg;
    bus_idx = rb_q;
    case (state_q)
      StT2: bus_idx = rc_q;
      StT3: begin
        if (op_q == OpMfhi) begin
          bus_sel = BusHi;
        end else if (op_q == OpMflo) begin
          bus_sel = BusLo;
        end else begin
          bus_sel = BusZlo;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    bus = '0;
    case (bus_sel)
      BusReg:  bus = regs_q[bus_idx];
      BusHi:   bus = hi_q;
      BusLo:   bus = lo_q;
      BusZlo:  bus = z_q[W-1:0];
      default: bus = '0;
    endcase
  end

  // A comes from Y, B straight off the bus.
  always_comb begin
    alu = '0;
    case (op_q)
      4'd0:    alu = y_q + bus;
      4'd1:    alu = y_q - bus;
      4'd2:    alu = y_q & bus;
      4'd3:    alu = y_q | bus;
      4'd4:    alu = y_q << bus[SW-1:0];
      4'd5:    alu = y_q >> bus[SW-1:0];
      4'd6:    alu = ~bus;
      4'd7:    alu = '0 - bus;
      default: alu = '0;
    endcase
  end

  // Right-shifting shift-add: add the multiplicand into the upper half, then shift Z right.
  assign acc_sum = {1'b0, z_q[2*W-1:W]} + {1'b0, (mq_q[0] ? y_q : {W{1'b0}})};

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    rc_d     = rc_q;
    y_d      = y_q;
    z_d      = z_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mq_d     = mq_q;
    cnt_d    = cnt_q;
    regs_d   = regs_q;
    rf_we    = 1'b0;
    rf_waddr = ra_q;
    rf_wdata = bus;
    case (state_q)
      StIdle: begin
        if (wr_en) begin
          rf_we    = 1'b1;
          rf_waddr = wr_addr;
          rf_wdata = wr_data;
        end
        if (start) begin
          op_d    = op;
          ra_d    = ra;
          rb_d    = rb;
          rc_d    = rc;
          state_d = StT1;
        end
      end
      StT1: begin
        y_d     = bus;
        state_d = StT2;
      end
      StT2: begin
        if (op_q == OpMul) begin
          mq_d    = bus;
          cnt_d   = CW'(W);
          z_d     = '0;
          state_d = StTm;
        end else begin
          z_d     = {{W{1'b0}}, alu};
          state_d = StT3;
        end
      end
      StTm: begin
        z_d   = {acc_sum, z_q[W-1:1]};
        mq_d  = mq_q >> 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = StT3;
        end
      end
      StT3: begin
        if (op_q == OpMul) begin
          hi_d = z_q[2*W-1:W];
          lo_d = z_q[W-1:0];
        end else if (!illegal) begin
          rf_we = 1'b1;
        end
        state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    rf_keep = 1'b1;
`ifdef R0_ZERO_EN
    rf_keep = (rf_waddr != '0);
`else
    rf_keep = 1'b1;
`endif
    if (rf_we && rf_keep) begin
      regs_d[rf_waddr] = rf_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= StIdle;
      op_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rc_q    <= '0;
      y_q     <= '0;
      z_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      mq_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rc_q    <= rc_d;
      y_q     <= y_d;
      z_q     <= z_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mq_q    <= mq_d;
      cnt_q   <= cnt_d;
      regs_q  <= regs_d;
      busy_q  <= (state_d != StIdle);
      done_q  <= (state_d == StDone);
      err_q   <= (state_d == StDone) && illegal;
    end
  end

  // R0 is never written when R0_ZERO_EN is set, so it reads back as its reset value of zero.
  always_comb begin
    rd_data = regs_q[rd_addr];
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign hi_out = hi_q;
  assign lo_out = lo_q;
  assign z_out  = z_q;

endmodule

// File: tb/tb_datapath_seq.sv
// Randomised scoreboard bench for datapath_seq: the stimulus process computes expected results
// from a behavioural model and queues them; a monitor pops and compares on every done pulse.
module tb_datapath_seq;

  localparam int W = 32;

  logic        clk, clr, start, wr_en;
  logic [3:0]  op, ra, rb, rc, wr_addr;
  logic [31:0] wr_data, rd_data, hi_out, lo_out;
  logic [63:0] z_out;
  logic        busy, done, err;
  logic        sweep;
  logic [3:0]  sw_addr, mon_addr;
  wire  [3:0]  rd_addr = sweep ? sw_addr : mon_addr;

  datapath_seq #(.W(32), .NREGS(16)) dut (
    .clk(clk), .clr(clr), .start(start), .op(op), .ra(ra), .rb(rb), .rc(rc),
    .busy(busy), .done(done), .err(err), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data), .hi_out(hi_out),
    .lo_out(lo_out), .z_out(z_out)
  );

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  ra;
    logic [31:0] rval;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [63:0] z;
    bit          zchk;
    logic        err;
    int          cap;
    int          lat;
  } exp_t;

  exp_t        q[$];
  logic [31:0] model_r [16];
  logic [31:0] model_hi, model_lo;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model_r[i] = '0;
    model_hi = '0;
    model_lo = '0;
  endtask

  task automatic model_wr(input logic [3:0] a, input logic [31:0] d);
`ifdef R0_ZERO_EN
    if (a != 4'd0) model_r[a] = d;
`else
    model_r[a] = d;
`endif
  endtask

  // Returns at a negedge with the DUT idle, or reports a timeout.
  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      errors++;
      checks++;
      $display("FAIL idle_timeout: busy=%b after %0d cycles", busy, n);
    end
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [31:0] d);
    wait_idle();
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk);
    #1 wr_en = 1'b0;
    model_wr(a, d);
  endtask

  task automatic issue(input logic [3:0] o, input logic [3:0] a_ra, input logic [3:0] a_rb,
                       input logic [3:0] a_rc, input bit push, input bit do_wr,
                       input logic [3:0] wa, input logic [31:0] wd);
    exp_t        e;
    logic [31:0] a, b, r;
    logic [63:0] p;
    bit          wb;
    wait_idle();
    if (do_wr) begin
      wr_en = 1'b1; wr_addr = wa; wr_data = wd;
      model_wr(wa, wd);
    end
    start = 1'b1; op = o; ra = a_ra; rb = a_rb; rc = a_rc;
    a = model_r[a_rb];
    b = model_r[a_rc];
    r = '0; wb = 1'b1;
    e.err = 1'b0; e.zchk = 1'b1; e.lat = 3;
    case (o)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a << (b % 32);
      4'd5: r = a >> (b % 32);
      4'd6: r = ~b;
      4'd7: r = 32'd0 - b;
      4'd8: begin
        p = {32'd0, a} * {32'd0, b};
        model_hi = p[63:32];
        model_lo = p[31:0];
        wb = 1'b0;
        e.lat = 3 + W;
      end
      4'd9:  begin r = model_hi; e.zchk = 1'b0; end
      4'd10: begin r = model_lo; e.zchk = 1'b0; end
      default: begin wb = 1'b0; e.err = 1'b1; e.zchk = 1'b0; end
    endcase
    if (wb) model_wr(a_ra, r);
    e.op = o; e.ra = a_ra; e.rval = model_r[a_ra];
    e.hi = model_hi; e.lo = model_lo;
    e.z = (o == 4'd8) ? {model_hi, model_lo} : {32'd0, r};
    @(posedge clk);
    #1;
    start = 1'b0; wr_en = 1'b0;
    e.cap = cyc;
    if (push) q.push_back(e);
  endtask

  task automatic sweep_regs(input string name);
    sweep = 1'b1;
    for (int i = 0; i < 16; i++) begin
      sw_addr = 4'(i);
      #1;
      chk(name, {32'd0, rd_data}, {32'd0, model_r[i]});
    end
    sweep = 1'b0;
  endtask

  // Monitor: compares every completion against the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (err && !done) begin
      errors++;
      checks++;
      $display("FAIL err_without_done: err=%b done=%b", err, done);
    end
    if (done && !sweep) begin
      if (q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_done: done=%b with empty scoreboard", done);
      end else begin
        e = q.pop_front();
        mon_addr = e.ra;
        #1;
        chk($sformatf("latency op%0d", e.op), 64'(cyc - e.cap), 64'(e.lat));
        chk($sformatf("err op%0d", e.op), {63'd0, err}, {63'd0, e.err});
        chk($sformatf("rd op%0d", e.op), {32'd0, rd_data}, {32'd0, e.rval});
        chk($sformatf("hi op%0d", e.op), {32'd0, hi_out}, {32'd0, e.hi});
        chk($sformatf("lo op%0d", e.op), {32'd0, lo_out}, {32'd0, e.lo});
        if (e.zchk) chk($sformatf("z op%0d", e.op), z_out, e.z);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    clr = 1'b1; start = 1'b0; wr_en = 1'b0; op = '0; ra = '0; rb = '0; rc = '0;
    wr_addr = '0; wr_data = '0; sweep = 1'b0; sw_addr = '0; mon_addr = '0;
    model_reset();
    repeat (3) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);

    // Reset state
    sweep_regs("reset_rd");
    chk("reset_hi", {32'd0, hi_out}, 64'd0);
    chk("reset_lo", {32'd0, lo_out}, 64'd0);
    chk("reset_z", z_out, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);

    // Directed: ADD, MUL with max operand, illegal op with ignored start/wr while busy
    wr_reg(4'd1, 32'd5);
    wr_reg(4'd2, 32'd7);
    issue(4'd0, 4'd3, 4'd1, 4'd2, 1'b1, 1'b0, 4'd0, 32'd0);
    wr_reg(4'd1, 32'hFFFF_FFFF);
    issue(4'd8, 4'd3, 4'd1, 4'd2, 1'b1, 1'b1, 4'd2, 32'd2);
    issue(4'd13, 4'd4, 4'd1, 4'd2, 1'b1, 1'b0, 4'd0, 32'd0);
    @(negedge clk);
    start = 1'b1; op = 4'd0; ra = 4'd5; rb = 4'd1; rc = 4'd2;
    wr_en = 1'b1; wr_addr = 4'd6; wr_data = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;

    // Shift amount uses only the low bits of B
    wr_reg(4'd1, 32'h8000_0000);
    issue(4'd5, 4'd3, 4'd1, 4'd2, 1'b1, 1'b1, 4'd2, 32'd33);
    issue(4'd9, 4'd7, 4'd1, 4'd2, 1'b1, 1'b0, 4'd0, 32'd0);
    issue(4'd10, 4'd8, 4'd1, 4'd2, 1'b1, 1'b0, 4'd0, 32'd0);
    wait_idle();
    sweep_regs("directed_rd");

    // Abort a multiply mid-run with clr
    issue(4'd8, 4'd9, 4'd1, 4'd1, 1'b0, 1'b0, 4'd0, 32'd0);
    repeat (5) @(negedge clk);
    chk("abort_busy_before", {63'd0, busy}, 64'd1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_reset();
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_hi", {32'd0, hi_out}, 64'd0);
    chk("abort_lo", {32'd0, lo_out}, 64'd0);
    sweep_regs("abort_rd");

    // R0 behaviour: write 9 and start in the same cycle, R0 = R0 + R0
    issue(4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 4'd0, 32'd9);

    // Randomised ops over random register contents
    for (int i = 1; i < 16; i++) wr_reg(4'(i), $urandom);
    for (int k = 0; k < 40; k++) begin
      logic [31:0] d;
      d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      issue(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 1'b1, ($urandom_range(0, 2) == 0),
            4'($urandom_range(0, 15)), d);
    end

    n = 0;
    while ((q.size() != 0 || busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(q.size()), 64'd0);
    @(negedge clk);
    sweep_regs("final_rd");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
